// File: rtl/axi4_burst_splitter_pkg.sv
// Shared constants, FSM state type and helpers for the AXI4 burst splitter.
package axi4_burst_splitter_pkg;

  localparam int unsigned AXI4_MAX_BURST_LEN  = 256;
  localparam int unsigned AXI4_BOUNDARY_BYTES = 4096;

  localparam logic AXI4_DIR_READ  = 1'b0;
  localparam logic AXI4_DIR_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_AXI_BURST_SPLIT_IDLE  = 2'd0,
    ST_AXI_BURST_SPLIT_CALC  = 2'd1,
    ST_AXI_BURST_SPLIT_ISSUE = 2'd2
  } st_axi4_burst_split_t;

  // Larger of two widths, used to size comparisons.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi4_burst_len_calc.sv
// Beats in the next burst: min(remaining, beat cap, beats left before the 4 KiB boundary).
module axi4_burst_len_calc
  import axi4_burst_splitter_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH  = 32,
  parameter int unsigned MAX_BURST_LEN   = AXI4_MAX_BURST_LEN,
  parameter int unsigned CMD_BEATS_WIDTH = 32
) (
  input  logic [11:0]                addr_offset,
  input  logic [CMD_BEATS_WIDTH-1:0] remaining,
  output logic [8:0]                 burst_beats_c
);

  localparam int unsigned BYTE_SHIFT = $clog2(AXI_DATA_WIDTH / 8);
  localparam int unsigned CMP_W      = max_u(CMD_BEATS_WIDTH, 13);

  logic [12:0]      bytes_to_4k;
  logic [CMP_W-1:0] beats_to_4k;
  logic [CMP_W-1:0] rem_ext;
  logic [CMP_W-1:0] cap;
  logic [CMP_W-1:0] beats;

  // Address is beat-aligned, so the shift divides exactly.
  always_comb begin
    bytes_to_4k = 13'(AXI4_BOUNDARY_BYTES) - {1'b0, addr_offset};
    beats_to_4k = CMP_W'(bytes_to_4k >> BYTE_SHIFT);
    rem_ext     = CMP_W'(remaining);
    cap         = CMP_W'(MAX_BURST_LEN);
    beats       = rem_ext;
    if (cap < beats)         beats = cap;
    if (beats_to_4k < beats) beats = beats_to_4k;
    burst_beats_c = 9'(beats);
  end

endmodule

// File: rtl/axi4_burst_splitter.sv
// Splits user transfer commands into AXI4 INCR burst descriptors (beat cap, no 4 KiB crossing).
module axi4_burst_splitter
  import axi4_burst_splitter_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH  = 32,
  parameter int unsigned AXI_DATA_WIDTH  = 32,
  parameter int unsigned MAX_BURST_LEN   = AXI4_MAX_BURST_LEN,
  parameter int unsigned CMD_BEATS_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [CMD_BEATS_WIDTH-1:0] cmd_beats,
  input  logic                       cmd_dir,
  output logic                       burst_valid,
  input  logic                       burst_ready,
  output logic [AXI_ADDR_WIDTH-1:0]  burst_addr,
  output logic [7:0]                 burst_len,
  output logic                       burst_dir,
  output logic                       burst_last,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned BYTES_PER_BEAT = AXI_DATA_WIDTH / 8;
  localparam int unsigned BYTE_SHIFT     = $clog2(BYTES_PER_BEAT);
  localparam int unsigned CMP_W          = max_u(CMD_BEATS_WIDTH, 13);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK = ~AXI_ADDR_WIDTH'(BYTES_PER_BEAT - 1);

  localparam logic [1:0] ST_IDLE  = ST_AXI_BURST_SPLIT_IDLE;
  localparam logic [1:0] ST_CALC  = ST_AXI_BURST_SPLIT_CALC;
  localparam logic [1:0] ST_ISSUE = ST_AXI_BURST_SPLIT_ISSUE;

  logic [1:0]                 state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [CMD_BEATS_WIDTH-1:0] remaining_q, remaining_d;
  logic                       dir_q, dir_d;
  logic [8:0]                 beats_q, beats_d;
  logic                       idle_q, idle_d;
  logic                       burst_valid_d;
  logic [AXI_ADDR_WIDTH-1:0]  burst_addr_d;
  logic [7:0]                 burst_len_d;
  logic                       burst_dir_d;
  logic                       burst_last_d;
  logic                       busy_d;
  logic                       done_d;
  logic [8:0]                 beats_c;

  axi4_burst_len_calc #(
    .AXI_DATA_WIDTH  (AXI_DATA_WIDTH),
    .MAX_BURST_LEN   (MAX_BURST_LEN),
    .CMD_BEATS_WIDTH (CMD_BEATS_WIDTH)
  ) u_len_calc (
    .addr_offset   (addr_q[11:0]),
    .remaining     (remaining_q),
    .burst_beats_c (beats_c)
  );

  // Ready is forced low while reset is held so no command slips in during reset.
  assign cmd_ready = idle_q & ~rst;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      dir_q       <= 1'b0;
      beats_q     <= '0;
      idle_q      <= 1'b1;
      burst_valid <= 1'b0;
      burst_addr  <= '0;
      burst_len   <= '0;
      burst_dir   <= 1'b0;
      burst_last  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
      beats_q     <= beats_d;
      idle_q      <= idle_d;
      burst_valid <= burst_valid_d;
      burst_addr  <= burst_addr_d;
      burst_len   <= burst_len_d;
      burst_dir   <= burst_dir_d;
      burst_last  <= burst_last_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    dir_d         = dir_q;
    beats_d       = beats_q;
    burst_valid_d = burst_valid;
    burst_addr_d  = burst_addr;
    burst_len_d   = burst_len;
    burst_dir_d   = burst_dir;
    burst_last_d  = burst_last;
    done_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d      = cmd_addr & ADDR_MASK;
          remaining_d = cmd_beats;
          dir_d       = cmd_dir;
          if (cmd_beats == '0) done_d  = 1'b1;
          else                 state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        beats_d       = beats_c;
        burst_addr_d  = addr_q;
        burst_len_d   = 8'(beats_c - 9'd1);
        burst_dir_d   = dir_q;
        burst_last_d  = (CMP_W'(beats_c) == CMP_W'(remaining_q));
        burst_valid_d = 1'b1;
        state_d       = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (burst_valid && burst_ready) begin
          burst_valid_d = 1'b0;
          addr_d        = addr_q + (AXI_ADDR_WIDTH'(beats_q) << BYTE_SHIFT);
          remaining_d   = remaining_q - CMD_BEATS_WIDTH'(beats_q);
          if (burst_last) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    idle_d = (state_d == ST_IDLE);
    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_axi4_burst_splitter.sv
// Scoreboard bench for axi4_burst_splitter: directed test-plan cases plus random commands.
module tb_axi4_burst_splitter;
  import axi4_burst_splitter_pkg::*;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned MBL   = 256;
  localparam int unsigned CBW   = 32;
  localparam int unsigned BYTES = DW / 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [AW-1:0]  cmd_addr = '0;
  logic [CBW-1:0] cmd_beats = '0;
  logic           cmd_dir = 1'b0;
  logic           burst_valid;
  logic           burst_ready = 1'b0;
  logic [AW-1:0]  burst_addr;
  logic [7:0]     burst_len;
  logic           burst_dir;
  logic           burst_last;
  logic           busy;
  logic           done;

  axi4_burst_splitter #(
    .AXI_ADDR_WIDTH (AW),
    .AXI_DATA_WIDTH (DW),
    .MAX_BURST_LEN  (MBL),
    .CMD_BEATS_WIDTH(CBW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_beats  (cmd_beats),
    .cmd_dir    (cmd_dir),
    .burst_valid(burst_valid),
    .burst_ready(burst_ready),
    .burst_addr (burst_addr),
    .burst_len  (burst_len),
    .burst_dir  (burst_dir),
    .burst_last (burst_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic        dir;
    logic        last;
  } burst_t;

  burst_t exp_q[$];
  int     n_checks   = 0;
  int     n_pass     = 0;
  int     cyc        = 0;
  int     valid_at   = -1;
  int     done_at    = -1;
  bit     in_reset   = 1'b1;
  int     ready_mode = 0;  // 0: always ready, 1: random, 2: driven by stimulus

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Reference: walk the command in plain arithmetic, emitting each legal burst.
  function automatic void model_push(input logic [31:0] addr, input int unsigned beats, input logic dir);
    longint unsigned a;
    longint unsigned rem;
    longint unsigned to4k;
    longint unsigned n;
    burst_t b;
    a   = addr - (addr % BYTES);
    rem = beats;
    while (rem > 0) begin
      to4k = (4096 - (a % 4096)) / BYTES;
      n = rem;
      if (n > MBL)  n = MBL;
      if (n > to4k) n = to4k;
      b.addr = 32'(a);
      b.len  = 8'(n - 1);
      b.dir  = dir;
      b.last = (n == rem);
      exp_q.push_back(b);
      a   = (a + n * BYTES) % 64'h1_0000_0000;
      rem = rem - n;
    end
  endfunction

  // burst_ready driver for the automatic modes.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0)      burst_ready = 1'b1;
      else if (ready_mode == 1) burst_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compares presented bursts against the scoreboard and checks handshake latencies.
  initial begin
    burst_t b;
    forever begin
      @(negedge clk);
      cyc++;
      if (!in_reset && !rst) begin
        if (cyc == valid_at)     chk("burst_valid_latency", burst_valid, 1);
        if (cyc == valid_at - 1) chk("burst_valid_early", burst_valid, 0);
        if (cyc == done_at) begin
          chk("done_pulse", done, 1);
          chk("cmd_ready_at_done", cmd_ready, 1);
          chk("busy_at_done", busy, 0);
        end else if (done) begin
          chk("done_unexpected", done, 0);
        end
        if (burst_valid) begin
          if (exp_q.size() == 0) begin
            chk("burst_unexpected", burst_valid, 0);
          end else begin
            b = exp_q[0];
            chk("burst_addr", burst_addr, b.addr);
            chk("burst_len", burst_len, b.len);
            chk("burst_dir", burst_dir, b.dir);
            chk("burst_last", burst_last, b.last);
            if (burst_ready) begin
              void'(exp_q.pop_front());
              if (b.last) done_at  = cyc + 1;
              else        valid_at = cyc + 2;
            end
          end
        end
        if (cmd_valid && cmd_ready) begin
          if (cmd_beats == '0) done_at  = cyc + 1;
          else                 valid_at = cyc + 2;
        end
      end
    end
  end

  task automatic send_cmd(input logic [31:0] a, input int unsigned beats, input logic d);
    int waited;
    waited = 0;
    @(posedge clk);
    #1;
    model_push(a, beats, d);
    cmd_addr  = a;
    cmd_beats = beats;
    cmd_dir   = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) chk("cmd_accept_timeout", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_beats = $urandom;
    cmd_dir   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy || done_at >= cyc) && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_queue", 64'(exp_q.size()), 0);
    chk("drain_busy", busy, 0);
  endtask

  // Watchdog so the bench always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;

    // Reset values.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_burst_valid", burst_valid, 0);
    chk("rst_burst_addr", burst_addr, 0);
    chk("rst_burst_len", burst_len, 0);
    chk("rst_burst_dir", burst_dir, 0);
    chk("rst_burst_last", burst_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    in_reset = 1'b0;

    // Directed cases with burst_ready held high.
    ready_mode = 0;
    send_cmd(32'h0000_1000, 16, AXI4_DIR_WRITE);
    wait_idle();
    send_cmd(32'h0000_0000, 600, AXI4_DIR_READ);
    wait_idle();
    send_cmd(32'h0000_0FF0, 8, AXI4_DIR_WRITE);
    wait_idle();
    send_cmd(32'h0000_1003, 1, AXI4_DIR_READ);
    wait_idle();
    send_cmd(32'h0000_4000, 0, AXI4_DIR_WRITE);
    wait_idle();
    send_cmd(32'hFFFF_FF00, 100, AXI4_DIR_WRITE);
    wait_idle();

    // Back-pressure: first burst held for five cycles.
    ready_mode  = 2;
    burst_ready = 1'b0;
    send_cmd(32'h0000_0000, 600, AXI4_DIR_WRITE);
    waited = 0;
    while (!burst_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("stall_valid_seen", burst_valid, 1);
    repeat (4) begin
      @(negedge clk);
      chk("stall_hold_valid", burst_valid, 1);
    end
    @(posedge clk);
    #1;
    burst_ready = 1'b1;
    ready_mode  = 0;
    wait_idle();

    // Reset in the cycle after the first burst handshake.
    send_cmd(32'h0000_0000, 600, AXI4_DIR_READ);
    waited = 0;
    @(negedge clk);
    while (!(burst_valid && burst_ready) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("reset_test_handshake", burst_valid && burst_ready, 1);
    @(posedge clk);
    #1;
    in_reset = 1'b1;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    valid_at = -1;
    done_at  = -1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_burst_valid", burst_valid, 0);
    chk("midrst_done", done, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_burst_addr", burst_addr, 0);
    in_reset = 1'b0;
    send_cmd(32'h0000_2000, 4, AXI4_DIR_WRITE);
    wait_idle();

    // Random commands under random back-pressure.
    ready_mode = 1;
    for (int i = 0; i < 20; i++) begin
      send_cmd($urandom, $urandom_range(0, 700), 1'($urandom_range(0, 1)));
      wait_idle();
    end
    ready_mode = 0;

    chk("final_queue_empty", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi4_burst_splitter.md
Name: axi4_burst_splitter

Overview:
- Command front-end directly upstream of the AXI4 master core.
- Accepts user transfer commands (start address, beat count, direction) and splits each into AXI4-legal INCR bursts for the master's address/data FSMs.
- Each emitted burst is at most MAX_BURST_LEN beats and never crosses a 4 KiB boundary.
- One command in flight at a time; valid/ready on both sides.

Parameters:
- AXI_ADDR_WIDTH, 32, address width.
- AXI_DATA_WIDTH, 32, data bus width in bits; bytes per beat = AXI_DATA_WIDTH/8, power of two, 8..1024.
- MAX_BURST_LEN, 256, beat cap per burst (AXI4_MAX_BURST_LEN); must be 1..256.
- CMD_BEATS_WIDTH, 32, width of the command beat count.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command ready.
- cmd_addr  in  AXI_ADDR_WIDTH  start byte address.
- cmd_beats  in  CMD_BEATS_WIDTH  total beats, 0 allowed.
- cmd_dir  in  1  AXI4_DIR_READ / AXI4_DIR_WRITE.
- burst_valid  out  1  burst descriptor valid.
- burst_ready  in  1  master accepts descriptor.
- burst_addr  out  AXI_ADDR_WIDTH  burst start address (beat-aligned).
- burst_len  out  8  AXI encoding, beats-1.
- burst_dir  out  1  copy of latched cmd_dir.
- burst_last  out  1  final burst of the current command.
- busy  out  1  command in progress (state != IDLE).
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Single clock; reset is synchronous and active-high.
- Reset values: cmd_ready=0 during rst, 1 in the first cycle after; burst_valid=0, burst_addr=0, burst_len=0, burst_dir=0, burst_last=0, busy=0, done=0; state=IDLE.
- FSM states: ST_IDLE, ST_CALC, ST_ISSUE.
- ST_IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch addr with low log2(bytes) bits forced to 0, remaining=cmd_beats, and dir.
  - If cmd_beats==0: done=1 next cycle, stay IDLE, no burst emitted. Otherwise go to CALC.
- ST_CALC (one cycle, cmd_ready=0):
  - beats_to_4k = (4096 - addr[11:0]) / bytes_per_beat.
  - n = min(remaining, MAX_BURST_LEN, beats_to_4k).
  - Register burst_addr=addr, burst_len=n-1, burst_last=(n==remaining), burst_valid=1.
  - Go to ISSUE.
  - Width rule: beats_to_4k needs 13 bits; compare at max(CMD_BEATS_WIDTH,13) bits.
- ST_ISSUE:
  - All burst_* outputs held stable while burst_valid & !burst_ready.
  - On handshake: burst_valid=0; addr += n*bytes_per_beat (modulo 2^AXI_ADDR_WIDTH, silent wrap); remaining -= n.
  - If remaining becomes 0: done=1 for one cycle, go to IDLE. Otherwise go to CALC.
- Latency:
  - Command handshake at cycle t gives burst_valid at t+2.
  - Burst handshake at t gives next burst_valid at t+2.
  - After the last burst handshake at t: done=1 and cmd_ready=1 at t+1.
- cmd_valid is ignored outside IDLE; no queuing.
- Reset mid-operation: the current command is dropped with no done pulse. All outputs return to reset values the cycle after rst.

Decomposition:
- Additions to axi_lib_pkg:
  - typedef enum st_axi4_burst_split_t {ST_AXI_BURST_SPLIT_IDLE, ST_AXI_BURST_SPLIT_CALC, ST_AXI_BURST_SPLIT_ISSUE}.
  - localparam AXI4_BOUNDARY_BYTES = 4096.
  - Reuse AXI4_MAX_BURST_LEN and AXI4_DIR_READ/WRITE.
- One natural combinational sub-module: axi4_burst_len_calc (addr, remaining -> n). It is unit-testable in isolation.

Test Plan (AXI_DATA_WIDTH=32, MAX_BURST_LEN=256):
- cmd addr=0x1000, beats=16, burst_ready=1 -> one burst addr=0x1000 len=15 last=1; done pulse 1 cycle after the burst handshake.
- addr=0x0000, beats=600 -> bursts (0x000,len 255,last 0), (0x400,len 255,last 0), (0x800,len 87,last 1); one done pulse only.
- 4 KiB crossing: addr=0x0FF0, beats=8 -> (0x0FF0,len 3,last 0), (0x1000,len 3,last 1). Unaligned addr=0x1003, beats=1 -> (0x1000,len 0,last 1).
- beats=0 -> cmd accepted, burst_valid stays 0, done=1 next cycle, cmd_ready stays 1.
- burst_ready held low 5 cycles during the first burst of the 600-beat command -> burst_addr/len/last/dir stable; accepted on cycle 6; next burst_valid 2 cycles later.
- rst asserted in the cycle after the first burst handshake of the 600-beat command -> next cycle busy=0, burst_valid=0, done=0, cmd_ready=1; a fresh addr=0x2000 beats=4 command yields (0x2000,len 3,last 1).
